// File: rtl/la_cmd_pkg.sv
// Shared definitions for the LogicAnalyzer2 command path: command codes,
// reply status bytes, reply table sizes and the responder state encoding.
package la_cmd_pkg;

  localparam logic [7:0] CMD_HELLO   = 8'h01;
  localparam logic [7:0] CMD_READ_SW = 8'h02;
  localparam logic [7:0] CMD_PING    = 8'h03;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Reply length of HELLO is fixed by the string table below; not tunable.
  localparam int HELLO_LEN = 11;
  // Width of the sampled switch word; READ_SW returns exactly two bytes.
  localparam int SW_WIDTH  = 16;
  // Index/length counter width; must hold HELLO_LEN.
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

endpackage

// File: rtl/uart_reply_rom.sv
// Reply table: maps (command, byte index, switch sample) to the reply byte
// and the total reply length. Purely combinational.
module uart_reply_rom
  import la_cmd_pkg::*;
(
  input  logic [7:0]          cmd,
  input  logic [IDX_W-1:0]    idx,
  input  logic [SW_WIDTH-1:0] sw_word,
  output logic [7:0]          reply_byte,
  output logic [IDX_W-1:0]    reply_len
);

  // "HELLO World" character table.
  function automatic logic [7:0] hello_char(input logic [IDX_W-1:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h48; // H
      4'd1:    c = 8'h45; // E
      4'd2:    c = 8'h4C; // L
      4'd3:    c = 8'h4C; // L
      4'd4:    c = 8'h4F; // O
      4'd5:    c = 8'h20; // space
      4'd6:    c = 8'h57; // W
      4'd7:    c = 8'h6F; // o
      4'd8:    c = 8'h72; // r
      4'd9:    c = 8'h6C; // l
      4'd10:   c = 8'h64; // d
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Select reply byte and length from the latched command.
  always_comb begin
    reply_byte = NAK;
    reply_len  = IDX_W'(1);
    case (cmd)
      CMD_HELLO: begin
        reply_byte = hello_char(idx);
        reply_len  = IDX_W'(HELLO_LEN);
      end
      CMD_READ_SW: begin
        reply_byte = (idx == '0) ? sw_word[15:8] : sw_word[7:0];
        reply_len  = IDX_W'(2);
      end
      CMD_PING: begin
        reply_byte = ACK;
        reply_len  = IDX_W'(1);
      end
      default: begin
        reply_byte = NAK;
        reply_len  = IDX_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Device-side command endpoint: pops one command byte from the UART receive
// FIFO, decodes it, and streams the reply into the transmit FIFO while
// honouring the transmit full flag.
module uart_cmd_responder
  import la_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_data_present,
  output logic                rx_read,
  output logic [7:0]          tx_data,
  output logic                tx_write,
  input  logic                tx_full,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                busy,
  output logic [7:0]          cmd_count
);

  state_t              state, state_nxt;
  logic [7:0]          cmd_reg;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    len_reg;
  logic [SW_WIDTH-1:0] sw_reg;
  logic [7:0]          rom_byte;
  logic [IDX_W-1:0]    rom_len;

  uart_reply_rom u_rom (
    .cmd        (cmd_reg),
    .idx        (idx),
    .sw_word    (sw_reg),
    .reply_byte (rom_byte),
    .reply_len  (rom_len)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the last byte leaves SEND only on an accepted write.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rx_data_present) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_SEND;
      ST_SEND:   if (!tx_full && (idx == len_reg - IDX_W'(1))) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, counters and switch sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg   <= 8'h00;
      cmd_count <= 8'h00;
      idx       <= '0;
      len_reg   <= '0;
      sw_reg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_data_present) begin
            cmd_reg   <= rx_data;
            cmd_count <= cmd_count + 8'd1;
          end
        end
        ST_DECODE: begin
          // Both READ_SW bytes come from this single sample.
          len_reg <= rom_len;
          idx     <= '0;
          sw_reg  <= sw;
        end
        ST_SEND: begin
          if (!tx_full) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // FIFO handshakes and status; rx_read is also masked while reset is held.
  always_comb begin
    rx_read  = (state == ST_IDLE) && rx_data_present && rst_n;
    tx_write = (state == ST_SEND) && !tx_full;
    tx_data  = (state == ST_SEND) ? rom_byte : 8'h00;
    busy     = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: models the rx FIFO as a queue, scores every
// transmitted byte against an expected-reply queue.
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_present;
  logic        rx_read;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_full;
  logic [15:0] sw;
  logic        busy;
  logic [7:0]  cmd_count;

  uart_cmd_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_data_present (rx_data_present),
    .rx_read         (rx_read),
    .tx_data         (tx_data),
    .tx_write        (tx_write),
    .tx_full         (tx_full),
    .sw              (sw),
    .busy            (busy),
    .cmd_count       (cmd_count)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int wr_cnt = 0;
  int pop_cyc = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  bit first_pend = 1'b0;

  // rx FIFO model plus tx scoreboard; samples 2 time units after the falling edge.
  always begin
    logic [7:0] e;
    @(negedge clk);
    rx_data_present = (rx_q.size() > 0);
    rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    #2;
    cyc++;
    if (rx_read) begin
      pop_cnt++;
      pop_cyc = cyc;
      first_pend = 1'b1;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (tx_full) begin
      total++;
      if (tx_write) begin
        bad++;
        $display("FAIL stall_write: tx_write=%0b while tx_full, required 0", tx_write);
      end
    end
    if (tx_write) begin
      wr_cnt++;
      if (first_pend) begin
        first_wr_cyc = cyc;
        first_pend = 1'b0;
      end
      last_wr_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_byte: got %02h, no byte expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [7:0] c);
    logic [7:0] hello [0:10];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    case (c)
      8'h01: for (int i = 0; i < 11; i++) exp_q.push_back(hello[i]);
      8'h02: begin
        exp_q.push_back(sw[15:8]);
        exp_q.push_back(sw[7:0]);
      end
      8'h03: exp_q.push_back(8'h06);
      default: exp_q.push_back(8'h15);
    endcase
    rx_q.push_back(c);
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: done=%0b required 1 (pending=%0d)", name, done, exp_q.size());
      exp_q.delete();
      rx_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({rx_read, tx_write, tx_data, busy, cmd_count} !== 19'd0) begin
      bad++;
      $display("FAIL %s: rd=%0b wr=%0b data=%02h busy=%0b cnt=%02h required all 0",
               name, rx_read, tx_write, tx_data, busy, cmd_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_full = 1'b0;
    sw = 16'h0000;
    repeat (3) @(negedge clk);
    rx_q.push_back(8'h01); // data present during reset must not be popped
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (rx_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_rx_read: got %0b required 0", rx_read);
    end
    total++;
    if (tx_write !== 1'b0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx: wr=%0b data=%02h required 0/00", tx_write, tx_data);
    end
    total++;
    if (busy !== 1'b0 || cmd_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_status: busy=%0b cnt=%02h required 0/00", busy, cmd_count);
    end
    rx_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hello();
    int p0 = pop_cnt;
    int w0 = wr_cnt;
    push_cmd(8'h01);
    wait_done(100, "hello");
    total++;
    if (pop_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL hello_pops: got %0d required 1", pop_cnt - p0);
    end
    total++;
    if (wr_cnt - w0 !== 11) begin
      bad++;
      $display("FAIL hello_writes: got %0d required 11", wr_cnt - w0);
    end
    total++;
    if (cmd_count !== 8'd1) begin
      bad++;
      $display("FAIL hello_count: got %0d required 1", cmd_count);
    end
    total++;
    if (first_wr_cyc - pop_cyc !== 2) begin
      bad++;
      $display("FAIL hello_first_latency: got %0d required 2", first_wr_cyc - pop_cyc);
    end
    total++;
    if (last_wr_cyc - pop_cyc !== 12) begin
      bad++;
      $display("FAIL hello_last_latency: got %0d required 12", last_wr_cyc - pop_cyc);
    end
  endtask

  task automatic test_read_sw();
    int p0 = pop_cnt;
    bit seen = 1'b0;
    sw = 16'hA55A;
    push_cmd(8'h02);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (pop_cnt > p0) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL read_sw_pop: seen=%0b required 1", seen);
    end
    @(posedge clk);   // pop edge
    @(posedge clk);   // decode edge, switch sampled here
    #1 sw = 16'h1234;
    wait_done(100, "read_sw");
    push_cmd(8'h02);  // second read must see the new sample
    wait_done(100, "read_sw2");
    total++;
    if (cmd_count !== 8'd3) begin
      bad++;
      $display("FAIL read_sw_count: got %0d required 3", cmd_count);
    end
  endtask

  task automatic test_back_to_back();
    int p0, w0;
    do_reset();
    p0 = pop_cnt;
    w0 = wr_cnt;
    push_cmd(8'h03);
    push_cmd(8'h7F);
    wait_done(100, "b2b");
    total++;
    if (cmd_count !== 8'd2) begin
      bad++;
      $display("FAIL b2b_count: got %0d required 2", cmd_count);
    end
    total++;
    if (pop_cnt - p0 !== 2) begin
      bad++;
      $display("FAIL b2b_pops: got %0d required 2", pop_cnt - p0);
    end
    total++;
    if (wr_cnt - w0 !== 2) begin
      bad++;
      $display("FAIL b2b_writes: got %0d required 2", wr_cnt - w0);
    end
  endtask

  task automatic test_stall();
    int w0 = wr_cnt;
    int ws;
    push_cmd(8'h01);
    for (int i = 0; i < 50 && wr_cnt < w0 + 4; i++) @(negedge clk);
    tx_full = 1'b1;
    ws = wr_cnt;
    repeat (5) @(negedge clk);
    total++;
    if (wr_cnt !== ws) begin
      bad++;
      $display("FAIL stall_hold: writes during stall=%0d required 0", wr_cnt - ws);
    end
    tx_full = 1'b0;
    wait_done(100, "stall");
    total++;
    if (wr_cnt - w0 !== 11) begin
      bad++;
      $display("FAIL stall_total: got %0d required 11", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    int w1;
    push_cmd(8'h01);
    for (int i = 0; i < 50 && wr_cnt < w0 + 6; i++) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("reset_mid_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w1 = wr_cnt;
    push_cmd(8'h01);
    wait_done(100, "reset_mid");
    total++;
    if (wr_cnt - w1 !== 11 || cmd_count !== 8'd1) begin
      bad++;
      $display("FAIL reset_mid_fresh: writes=%0d cnt=%0d required 11/1", wr_cnt - w1, cmd_count);
    end
  endtask

  task automatic test_wrap();
    int p0, w0;
    do_reset();
    p0 = pop_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 256; i++) push_cmd(8'h03);
    wait_done(4000, "wrap");
    total++;
    if (cmd_count !== 8'h00) begin
      bad++;
      $display("FAIL wrap_count: got %02h required 00", cmd_count);
    end
    total++;
    if (pop_cnt - p0 !== 256 || wr_cnt - w0 !== 256) begin
      bad++;
      $display("FAIL wrap_traffic: pops=%0d acks=%0d required 256/256", pop_cnt - p0, wr_cnt - w0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_full = 1'b0;
    sw = 16'h0000;
    rx_data = 8'h00;
    rx_data_present = 1'b0;
    test_reset();
    test_hello();
    test_read_sw();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Device-side command endpoint of the LogicAnalyzer2 command-and-control path. Sits between the uart_rx6 and uart_tx6 buffer macros inside nexys4fpga. Pops one command byte at a time from the receive FIFO, decodes it, and streams the fixed-length reply into the transmit FIFO under full-flag back-pressure. This is the responder the host (or bench) talks to when it writes 0x01 and expects "HELLO World" back.

## Interface
- HELLO_LEN, 11, byte count of the HELLO reply; fixed by the reply table, not tunable.
- SW_WIDTH, 16, width of the sampled switch word; must be 16.
- clk  in  1  100 MHz system clock; all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low. Driven from btnCpuReset.
- rx_data  in  8  uart_rx6 data_out; valid whenever rx_data_present=1.
- rx_data_present  in  1  uart_rx6 buffer_data_present.
- rx_read  out  1  uart_rx6 buffer_read; one-cycle pop strobe.
- tx_data  out  8  uart_tx6 data_in.
- tx_write  out  1  uart_tx6 buffer_write; one strobe per byte.
- tx_full  in  1  uart_tx6 buffer_full.
- sw  in  16  board switches, returned by READ_SW.
- busy  out  1  high while a command is being decoded or answered.
- cmd_count  out  8  number of commands accepted, wraps.

## Operation
- Command codes: 0x01 HELLO -> 48 45 4C 4C 4F 20 57 6F 72 6C 64 ("HELLO World", 11 bytes); 0x02 READ_SW -> sw[15:8], sw[7:0]; 0x03 PING -> 0x06 (ACK); any other code -> 0x15 (NAK).
- States: IDLE, DECODE, SEND.
- IDLE: rx_read = rx_data_present (combinational). On an edge with rx_data_present=1: cmd_reg <= rx_data, cmd_count <= cmd_count+1, go DECODE.
- DECODE: one cycle; load reply length (11/2/1/1) and idx=0; for READ_SW latch sw into sw_reg here so both bytes come from the same sample. Go SEND.
- SEND: tx_write = ~tx_full (combinational); tx_data = reply byte[idx]. On edge with tx_write=1: idx++; if idx was len-1, go IDLE. tx_full=1 stalls with idx held; no byte dropped or duplicated.
- tx_data = 0x00 outside SEND. busy = (state != IDLE).
- Bytes arriving while busy remain in the rx FIFO; served in order after return to IDLE. Never more than one pop per command.
- cmd_count counts unknown codes too; 0xFF -> 0x00.

## Timing
- Reset (async assert): state=IDLE, cmd_reg=0, idx=0, cmd_count=0; rx_read=0, tx_write=0, tx_data=0x00, busy=0. A reply in progress is abandoned, not resumed; the remaining rx FIFO contents are handled by the FIFO's own reset.
- Command byte present in IDLE at cycle N: rx_read=1 at N; DECODE at N+1; first tx_write at N+2 if tx_full=0.
- Unstalled reply of L bytes: writes in cycles N+2 .. N+1+L; IDLE at N+2+L. HELLO: last write at N+12, busy high N+1..N+12.
- Minimum spacing between consecutive pops: L+2 cycles. This guarantees rx_data_present has updated after each pop.
- tx_full sampled in the same cycle as the write; no one-cycle overflow window.

## Structure
- Shared package la_cmd_pkg: command codes (CMD_HELLO=0x01, CMD_READ_SW=0x02, CMD_PING=0x03), ACK=0x06, NAK=0x15, HELLO_LEN, state encodings.
- One sub-module, uart_reply_rom: combinational. Input is (cmd_reg, idx, sw_reg); output is the reply byte and length. Holds the HELLO string table.
- Top does the FSM, counters and handshakes only.

## Test plan
- Reset held, then released; write 0x01 -> rx_read one cycle, exactly 11 tx_write strobes carrying 48 45 4C 4C 4F 20 57 6F 72 6C 64, busy drops, cmd_count=1.
- sw=0xA55A, write 0x02 -> 2 bytes A5, 5A. Change sw during DECODE+1 -> bytes still match the DECODE-cycle sample.
- Writes of 0x03 then 0x7F, back-to-back into the rx FIFO -> 06 then 15, in order; cmd_count=2; exactly two rx_read pulses.
- Force tx_full=1 for 5 cycles mid-HELLO (after byte 4) -> no tx_write while full; resumes at byte 5 ('O'); total still 11 bytes.
- rst_n asserted at byte 6 of HELLO -> all outputs 0 immediately; after release, write 0x01 -> a full fresh 11-byte reply.
- 256 PING commands -> cmd_count wraps to 0x00; 256 ACK bytes received.
